f_writeback_arbiter: RTL

- Merges floating-point results from the FPU pipeline, the divide/sqrt unit and the FP load unit onto the single write port of the FP register file.
- Each source has a one-entry holding buffer with a valid/ready handshake; a round-robin arbiter selects one buffer per cycle into a registered write port.
- A pending-write mask lets the issue stage stall on RAW and WAW hazards against writes still in flight.

---
 rtl/Modules_pkg.sv | 33 +++
 rtl/f_wb_rr_arbiter.sv | 35 +++
 rtl/f_writeback_arbiter.sv | 93 +++++++++
 3 files changed

// File: rtl/Modules_pkg.sv
// Shared FP types and the writeback-arbiter payload definitions.
package Modules_pkg;

  // FP architectural register names f0..f31.
  typedef enum logic [4:0] {
    F0,  F1,  F2,  F3,  F4,  F5,  F6,  F7,
    F8,  F9,  F10, F11, F12, F13, F14, F15,
    F16, F17, F18, F19, F20, F21, F22, F23,
    F24, F25, F26, F27, F28, F29, F30, F31
  } f_register_e;

  // Single-precision value as raw bits.
  typedef logic [31:0] float_t;

  localparam int unsigned FWB_SRCS = 3;

  typedef enum logic [1:0] {
    FWB_FPU = 2'd0,
    FWB_DIV = 2'd1,
    FWB_LD  = 2'd2
  } f_wb_src_e;

  typedef struct packed {
    f_register_e faddr;
    float_t      fdata;
  } f_wb_entry_t;

  // One-hot register mask used to build the pending-write vector.
  function automatic logic [31:0] f_reg_onehot(f_register_e r);
    return 32'(1) << r;
  endfunction

endpackage

// File: rtl/f_wb_rr_arbiter.sv
// Combinational round-robin picker: search starts one past the last grant.
module f_wb_rr_arbiter
  import Modules_pkg::*;
#(
  parameter int unsigned N_SRC = FWB_SRCS,
  localparam int unsigned IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic [N_SRC-1:0] req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [N_SRC-1:0] grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_vld
);

  logic [IDX_W-1:0] cand;

  // Walk candidates in rotated order and take the first requester.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    cand      = '0;
    for (int unsigned off = 1; off <= N_SRC; off++) begin
      cand = IDX_W'((32'(last_grant) + off) % N_SRC);
      if (!grant_vld && req[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
    if (grant_vld) begin
      grant[grant_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/f_writeback_arbiter.sv
// Merges FPU, DIV/SQRT and FP-load results onto the single FP regfile write port.
module f_writeback_arbiter
  import Modules_pkg::*;
#(
  parameter int unsigned N_SRC = FWB_SRCS
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [N_SRC-1:0]  src_valid_i,
  input  f_register_e       src_faddr_i [N_SRC],
  input  float_t            src_fdata_i [N_SRC],
  output logic [N_SRC-1:0]  src_ready_o,
  output logic              we_o,
  output f_register_e       w_faddr_o,
  output float_t            wr_fdata_o,
  output logic [31:0]       pending_o
);

  localparam int unsigned IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  logic [N_SRC-1:0] buf_valid;
  f_wb_entry_t      buf_q [N_SRC];
  logic [IDX_W-1:0] last_grant;
  logic [N_SRC-1:0] grant;
  logic [IDX_W-1:0] grant_idx;
  logic             grant_vld;
  logic [N_SRC-1:0] xfer;

  f_wb_rr_arbiter #(
    .N_SRC (N_SRC)
  ) u_rr (
    .req        (buf_valid),
    .last_grant (last_grant),
    .grant      (grant),
    .grant_idx  (grant_idx),
    .grant_vld  (grant_vld)
  );

  // Ready comes only from registered state: empty, or draining this cycle.
  assign src_ready_o = ~buf_valid | grant;
  assign xfer        = src_valid_i & src_ready_o;

  // Per-source holding buffers; a same-cycle transfer reloads a granted buffer.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      buf_valid <= '0;
      for (int unsigned s = 0; s < N_SRC; s++) begin
        buf_q[s] <= '0;
      end
    end else begin
      for (int unsigned s = 0; s < N_SRC; s++) begin
        if (xfer[s]) begin
          buf_valid[s]   <= 1'b1;
          buf_q[s].faddr <= src_faddr_i[s];
          buf_q[s].fdata <= src_fdata_i[s];
        end else if (grant[s]) begin
          buf_valid[s] <= 1'b0;
        end
      end
    end
  end

  // Registered write port and round-robin pointer; address/data hold when idle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      we_o       <= 1'b0;
      w_faddr_o  <= F0;
      wr_fdata_o <= '0;
      last_grant <= IDX_W'(N_SRC - 1);
    end else if (grant_vld) begin
      we_o       <= 1'b1;
      w_faddr_o  <= buf_q[grant_idx].faddr;
      wr_fdata_o <= buf_q[grant_idx].fdata;
      last_grant <= grant_idx;
    end else begin
      we_o <= 1'b0;
    end
  end

  // Registers with a write buffered or on the output port, for issue-stage hazard stalls.
  always_comb begin
    pending_o = '0;
    for (int unsigned s = 0; s < N_SRC; s++) begin
      if (buf_valid[s]) begin
        pending_o = pending_o | f_reg_onehot(buf_q[s].faddr);
      end
    end
    if (we_o) begin
      pending_o = pending_o | f_reg_onehot(w_faddr_o);
    end
  end

endmodule
